// File: rtl/axi_lite_arbiter.sv
// Two-master AXI-Lite arbiter: M0 (fetch) and M1 (load/store) share one slave, one transaction
// at a time. Round-robin by default; define ARB_FIXED_PRIO_EN to make M1 win every contention.
module axi_lite_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    // M0 upstream port
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    output logic [1:0]              s0_bresp,
    // M1 upstream port
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [1:0]              s1_bresp,
    // downstream port to the RAM slave
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [1:0]              m_bresp
);

    typedef enum logic [1:0] {StIdle, StRd, StWr} state_e;

    state_e state_q;
    logic   gnt_q;
    logic   ar_done_q, aw_done_q, w_done_q;
    logic   req0, req1, winner, win_ar;
`ifndef ARB_FIXED_PRIO_EN
    logic   last_q;
`endif

    always_comb begin
        req0 = s0_arvalid | s0_awvalid;
        req1 = s1_arvalid | s1_awvalid;
`ifdef ARB_FIXED_PRIO_EN
        winner = req1;
`else
        winner = (req0 & req1) ? ~last_q : req1;
`endif
        // Read beats write when the winner presents both.
        win_ar = winner ? s1_arvalid : s0_arvalid;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            gnt_q     <= 1'b0;
            ar_done_q <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            last_q    <= 1'b1;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    if (req0 | req1) begin
                        gnt_q     <= winner;
`ifndef ARB_FIXED_PRIO_EN
                        last_q    <= winner;
`endif
                        state_q   <= win_ar ? StRd : StWr;
                        ar_done_q <= 1'b0;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                StRd: begin
                    if (m_arvalid & m_arready) ar_done_q <= 1'b1;
                    if (m_rvalid & m_rready)   state_q   <= StIdle;
                end
                StWr: begin
                    if (m_awvalid & m_awready) aw_done_q <= 1'b1;
                    if (m_wvalid & m_wready)   w_done_q  <= 1'b1;
                    if (m_bvalid & m_bready)   state_q   <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    logic                    rd, wr;
    logic                    g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
    logic [ADDR_WIDTH-1:0]   g_araddr, g_awaddr;
    logic [DATA_WIDTH-1:0]   g_wdata;
    logic [DATA_WIDTH/8-1:0] g_wstrb;
    logic                    ar_rdy, aw_rdy, w_rdy, r_vld, b_vld;

    always_comb begin
        rd = (state_q == StRd);
        wr = (state_q == StWr);

        g_arvalid = gnt_q ? s1_arvalid : s0_arvalid;
        g_araddr  = gnt_q ? s1_araddr  : s0_araddr;
        g_rready  = gnt_q ? s1_rready  : s0_rready;
        g_awvalid = gnt_q ? s1_awvalid : s0_awvalid;
        g_awaddr  = gnt_q ? s1_awaddr  : s0_awaddr;
        g_wvalid  = gnt_q ? s1_wvalid  : s0_wvalid;
        g_wdata   = gnt_q ? s1_wdata   : s0_wdata;
        g_wstrb   = gnt_q ? s1_wstrb   : s0_wstrb;
        g_bready  = gnt_q ? s1_bready  : s0_bready;

        // Done flags mask a master that keeps a valid up after its handshake.
        m_arvalid = rd & g_arvalid & ~ar_done_q;
        m_araddr  = rd ? g_araddr : '0;
        m_rready  = rd & g_rready;
        m_awvalid = wr & g_awvalid & ~aw_done_q;
        m_awaddr  = wr ? g_awaddr : '0;
        m_wvalid  = wr & g_wvalid & ~w_done_q;
        m_wdata   = wr ? g_wdata : '0;
        m_wstrb   = wr ? g_wstrb : '0;
        m_bready  = wr & g_bready;

        ar_rdy = rd & m_arready & ~ar_done_q;
        aw_rdy = wr & m_awready & ~aw_done_q;
        w_rdy  = wr & m_wready & ~w_done_q;
        r_vld  = rd & m_rvalid;
        b_vld  = wr & m_bvalid;

        s0_arready = ar_rdy & ~gnt_q;
        s1_arready = ar_rdy & gnt_q;
        s0_awready = aw_rdy & ~gnt_q;
        s1_awready = aw_rdy & gnt_q;
        s0_wready  = w_rdy & ~gnt_q;
        s1_wready  = w_rdy & gnt_q;
        s0_rvalid  = r_vld & ~gnt_q;
        s1_rvalid  = r_vld & gnt_q;
        s0_bvalid  = b_vld & ~gnt_q;
        s1_bvalid  = b_vld & gnt_q;
        s0_rdata   = (rd & ~gnt_q) ? m_rdata : '0;
        s1_rdata   = (rd & gnt_q)  ? m_rdata : '0;
        s0_rresp   = (rd & ~gnt_q) ? m_rresp : 2'b00;
        s1_rresp   = (rd & gnt_q)  ? m_rresp : 2'b00;
        s0_bresp   = (wr & ~gnt_q) ? m_bresp : 2'b00;
        s1_bresp   = (wr & gnt_q)  ? m_bresp : 2'b00;
    end

endmodule

// File: tb/tb_axi_lite_arbiter.sv
// Directed bench for axi_lite_arbiter: RAM slave model, response scoreboard, immediate assertions.
// Contention expectations follow ARB_FIXED_PRIO_EN when it is defined.
module tb_axi_lite_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]  s_arvalid, s_arready, s_rvalid, s_rready, s_awvalid, s_awready;
    logic [1:0]  s_wvalid, s_wready, s_bvalid, s_bready;
    logic [31:0] s_araddr [2];
    logic [31:0] s_rdata  [2];
    logic [31:0] s_awaddr [2];
    logic [31:0] s_wdata  [2];
    logic [3:0]  s_wstrb  [2];
    logic [1:0]  s_rresp  [2];
    logic [1:0]  s_bresp  [2];

    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_awvalid, m_awready;
    logic        m_wvalid, m_wready, m_bvalid, m_bready;
    logic [31:0] m_araddr, m_rdata, m_awaddr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [1:0]  m_rresp, m_bresp;

    axi_lite_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .s0_arvalid(s_arvalid[0]), .s0_arready(s_arready[0]), .s0_araddr(s_araddr[0]),
        .s0_rvalid(s_rvalid[0]), .s0_rready(s_rready[0]), .s0_rdata(s_rdata[0]),
        .s0_rresp(s_rresp[0]), .s0_awvalid(s_awvalid[0]), .s0_awready(s_awready[0]),
        .s0_awaddr(s_awaddr[0]), .s0_wvalid(s_wvalid[0]), .s0_wready(s_wready[0]),
        .s0_wdata(s_wdata[0]), .s0_wstrb(s_wstrb[0]), .s0_bvalid(s_bvalid[0]),
        .s0_bready(s_bready[0]), .s0_bresp(s_bresp[0]),
        .s1_arvalid(s_arvalid[1]), .s1_arready(s_arready[1]), .s1_araddr(s_araddr[1]),
        .s1_rvalid(s_rvalid[1]), .s1_rready(s_rready[1]), .s1_rdata(s_rdata[1]),
        .s1_rresp(s_rresp[1]), .s1_awvalid(s_awvalid[1]), .s1_awready(s_awready[1]),
        .s1_awaddr(s_awaddr[1]), .s1_wvalid(s_wvalid[1]), .s1_wready(s_wready[1]),
        .s1_wdata(s_wdata[1]), .s1_wstrb(s_wstrb[1]), .s1_bvalid(s_bvalid[1]),
        .s1_bready(s_bready[1]), .s1_bresp(s_bresp[1]),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr),
        .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
        .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp)
    );

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEAD_BEEF : {16'hC0DE, 12'h000, 4'(i)};
    endfunction

    // RAM slave: 1-cycle read latency, SLVERR when addr[31]=0, B after both AW and W.
    logic [31:0] ram [16];
    bit          inited = 1'b0;
    logic        have_aw, have_w;
    logic [31:0] aw_a, w_d;
    logic [3:0]  w_s;
    int          ar_cnt = 0, aw_cnt = 0, w_cnt = 0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rvalid <= 1'b0; m_bvalid <= 1'b0; m_rdata <= '0; m_rresp <= '0; m_bresp <= '0;
            have_aw <= 1'b0; have_w <= 1'b0;
            if (!inited) begin
                for (int i = 0; i < 16; i++) ram[i] <= init_word(i);
                inited <= 1'b1;
            end
        end else begin
            if (m_arvalid && m_arready) begin
                ar_cnt   <= ar_cnt + 1;
                m_rvalid <= 1'b1;
                m_rdata  <= ram[m_araddr[5:2]];
                m_rresp  <= m_araddr[31] ? 2'b00 : 2'b10;
            end else if (m_rvalid && m_rready) begin
                m_rvalid <= 1'b0;
            end
            if (m_awvalid && m_awready) begin
                aw_cnt <= aw_cnt + 1; have_aw <= 1'b1; aw_a <= m_awaddr;
            end
            if (m_wvalid && m_wready) begin
                w_cnt <= w_cnt + 1; have_w <= 1'b1; w_d <= m_wdata; w_s <= m_wstrb;
            end
            if (have_aw && have_w && !m_bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (w_s[b]) ram[aw_a[5:2]][8*b +: 8] <= w_d[8*b +: 8];
                m_bvalid <= 1'b1;
                m_bresp  <= aw_a[31] ? 2'b00 : 2'b10;
                have_aw  <= 1'b0;
                have_w   <= 1'b0;
            end else if (m_bvalid && m_bready) begin
                m_bvalid <= 1'b0;
            end
        end
    end

    logic       any_out;
    logic [1:0] port_busy;
    assign any_out = |{m_arvalid, m_awvalid, m_wvalid, m_rready, m_bready, m_araddr, m_awaddr,
                       m_wdata, m_wstrb, s_arready, s_awready, s_wready, s_rvalid, s_bvalid,
                       s_rdata[0], s_rdata[1], s_rresp[0], s_rresp[1], s_bresp[0], s_bresp[1]};
    assign port_busy[0] = |{s_arready[0], s_awready[0], s_wready[0], s_rvalid[0], s_bvalid[0],
                            s_rdata[0], s_rresp[0], s_bresp[0]};
    assign port_busy[1] = |{s_arready[1], s_awready[1], s_wready[1], s_rvalid[1], s_bvalid[1],
                            s_rdata[1], s_rresp[1], s_bresp[1]};

    typedef struct {
        int          port;
        logic [31:0] data;
        logic [1:0]  resp;
    } exp_t;

    exp_t        sb [$];
    logic [31:0] model [16];
    int          total = 0, bad = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rd(input int p, input logic [31:0] addr);
        exp_t e;
        e.port = p;
        e.data = model[addr[5:2]];
        e.resp = addr[31] ? 2'b00 : 2'b10;
        sb.push_back(e);
    endtask

    task automatic push_wr(input int p, input logic [31:0] addr, input logic [31:0] data,
                           input logic [3:0] strb);
        exp_t e;
        for (int b = 0; b < 4; b++)
            if (strb[b]) model[addr[5:2]][8*b +: 8] = data[8*b +: 8];
        e.port = p;
        e.data = '0;
        e.resp = addr[31] ? 2'b00 : 2'b10;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag, input int p, input logic [31:0] d,
                           input logic [1:0] r, input bit is_rd);
        exp_t e;
        check({tag, "_sb_nonempty"}, sb.size() > 0, 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({tag, "_port"}, p, e.port);
            if (is_rd) check({tag, "_data"}, d, e.data);
            check({tag, "_resp"}, r, e.resp);
        end
    endtask

    task automatic rd(input int p, input logic [31:0] addr);
        bit hs; int n; logic [31:0] d; logic [1:0] r;
        s_arvalid[p] = 1'b1; s_araddr[p] = addr; s_rready[p] = 1'b1;
        hs = 0; n = 0;
        while (!hs && n < 50) begin
            @(negedge clk); hs = s_arready[p]; tick(); n++;
        end
        s_arvalid[p] = 1'b0;
        check("ar_handshake", hs, 1);
        hs = 0; n = 0; d = '0; r = '0;
        while (!hs && n < 50) begin
            @(negedge clk);
            if (s_rvalid[p]) begin hs = 1; d = s_rdata[p]; r = s_rresp[p]; end
            tick(); n++;
        end
        s_rready[p] = 1'b0;
        check("r_handshake", hs, 1);
        pop_cmp("rd", p, d, r, 1'b1);
    endtask

    task automatic wr(input int p, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] strb, input int lead, input bit hold_w);
        bit aw_ok, w_ok, b_ok; int n, w_seen; logic [1:0] r;
        aw_ok = 0; w_ok = 0; b_ok = 0; n = 0; w_seen = 0; r = '0;
        s_wvalid[p] = 1'b1; s_wdata[p] = data; s_wstrb[p] = strb; s_bready[p] = 1'b1;
        repeat (lead) tick();
        s_awvalid[p] = 1'b1; s_awaddr[p] = addr;
        while (!b_ok && n < 60) begin
            @(negedge clk);
            if (s_awvalid[p] && s_awready[p]) aw_ok = 1;
            if (s_wvalid[p] && s_wready[p]) begin w_ok = 1; w_seen++; end
            if (s_bvalid[p]) begin b_ok = 1; r = s_bresp[p]; end
            tick(); n++;
            if (aw_ok) s_awvalid[p] = 1'b0;
            if (w_ok && !hold_w) s_wvalid[p] = 1'b0;
        end
        s_awvalid[p] = 1'b0; s_wvalid[p] = 1'b0; s_bready[p] = 1'b0;
        check("b_handshake", b_ok, 1);
        check("w_ready_once", w_seen, 1);
        pop_cmp("wr", p, '0, r, 1'b0);
    endtask

    task automatic watch_quiet(input int p, input int n);
        repeat (n) begin
            @(negedge clk);
            check("quiet_port", port_busy[p], 1'b0);
        end
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check(tag, any_out, 1'b0);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int aw0, w0, ar0;
        bit got;
        s_arvalid = '0; s_rready = '0; s_awvalid = '0; s_wvalid = '0; s_bready = '0;
        for (int i = 0; i < 2; i++) begin
            s_araddr[i] = '0; s_awaddr[i] = '0; s_wdata[i] = '0; s_wstrb[i] = '0;
        end
        m_arready = 1'b1; m_awready = 1'b1; m_wready = 1'b1;
        for (int i = 0; i < 16; i++) model[i] = init_word(i);

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", any_out, 1'b0);
        tick();
        rst_n = 1'b1;
        expect_idle("idle_outputs");

        // Single read by M0 with one-cycle arbitration latency.
        push_rd(0, 32'h8000_0010);
        fork
            rd(0, 32'h8000_0010);
            begin
                @(negedge clk); check("lat_cycle_n", m_arvalid, 1'b0);
                @(negedge clk); check("lat_cycle_n1", m_arvalid, 1'b1);
                check("lat_araddr", m_araddr, 32'h8000_0010);
            end
            watch_quiet(1, 4);
        join
        expect_idle("rd_back_idle");

        // Single partial write by M1, then read back through M0.
        push_wr(1, 32'h8000_0020, 32'h1234_5678, 4'b0011);
        fork
            wr(1, 32'h8000_0020, 32'h1234_5678, 4'b0011, 0, 1'b0);
            watch_quiet(0, 5);
        join
        expect_idle("wr_back_idle");
        push_rd(0, 32'h8000_0020);
        rd(0, 32'h8000_0020);
        expect_idle("rb_back_idle");

        // Error response passes through unchanged.
        push_rd(1, 32'h0000_0008);
        rd(1, 32'h0000_0008);
        expect_idle("err_back_idle");

        // Read-over-write on M0: write is arbitrated in a later IDLE cycle.
        aw0 = aw_cnt;
        push_rd(0, 32'h8000_0014);
        push_wr(0, 32'h8000_0014, 32'hAABB_CCDD, 4'hF);
        fork
            begin
                rd(0, 32'h8000_0014);
                check("row_no_aw_yet", aw_cnt - aw0, 0);
                @(negedge clk); check("row_gap_idle", m_awvalid, 1'b0);
                @(negedge clk); check("row_wr_start", m_awvalid, 1'b1);
            end
            wr(0, 32'h8000_0014, 32'hAABB_CCDD, 4'hF, 0, 1'b0);
        join
        expect_idle("row_back_idle");
        push_rd(1, 32'h8000_0014);
        rd(1, 32'h8000_0014);
        expect_idle("row_rb_idle");

        // Split write: W leads AW by 3 cycles, slave stalls AW, master keeps wvalid up.
        aw0 = aw_cnt; w0 = w_cnt;
        m_awready = 1'b0;
        push_wr(1, 32'h8000_0024, 32'h0BAD_F00D, 4'hF);
        fork
            wr(1, 32'h8000_0024, 32'h0BAD_F00D, 4'hF, 3, 1'b1);
            begin
                repeat (6) @(posedge clk);
                @(negedge clk);
                check("split_w_masked", m_wvalid, 1'b0);
                check("split_wready_masked", s_wready[1], 1'b0);
                check("split_aw_waiting", m_awvalid, 1'b1);
                tick();
                m_awready = 1'b1;
            end
            watch_quiet(0, 10);
        join
        check("split_aw_once", aw_cnt - aw0, 1);
        check("split_w_once", w_cnt - w0, 1);
        expect_idle("split_back_idle");

        // Reset while M1's write sits in WR with only AW done.
        s_bready[1] = 1'b1;
        s_awvalid[1] = 1'b1; s_awaddr[1] = 32'h8000_0028;
        got = 0;
        for (int n = 0; n < 10 && !got; n++) begin
            @(negedge clk); got = s_awready[1]; tick();
        end
        s_awvalid[1] = 1'b0;
        check("mid_aw_handshake", got, 1);
        @(negedge clk);
        check("mid_in_wr", m_bready, 1'b1);
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        s_bready[1] = 1'b0;
        aw0 = aw_cnt; w0 = w_cnt; ar0 = ar_cnt;
        @(negedge clk);
        check("mid_rst_outputs", any_out, 1'b0);
        tick();

        // Contention straight after reset, both masters reissuing reads.
`ifdef ARB_FIXED_PRIO_EN
        push_rd(1, 32'h8000_0010);
        push_rd(1, 32'h8000_0024);
        push_rd(0, 32'h8000_0004);
        push_rd(0, 32'h8000_0020);
`else
        push_rd(0, 32'h8000_0004);
        push_rd(1, 32'h8000_0010);
        push_rd(0, 32'h8000_0020);
        push_rd(1, 32'h8000_0024);
`endif
        fork
            begin rd(0, 32'h8000_0004); rd(0, 32'h8000_0020); end
            begin rd(1, 32'h8000_0010); rd(1, 32'h8000_0024); end
        join
        expect_idle("cont_back_idle");
        check("mid_no_aw_after", aw_cnt - aw0, 0);
        check("mid_no_w_after", w_cnt - w0, 0);
        check("cont_ar_count", ar_cnt - ar0, 4);
        check("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
